memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter ADDR_W, default 30, width of the word address presented to the data cache.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 WriteBack_3  input  1  EX/MEM register write-back enable.
REQ-005 Mem_3  input  2  EX/MEM memory control: bit1 = read (load), bit0 = write (store).
REQ-006 ALU_result_3  input  32  byte address for loads/stores, or result for non-memory ops.
REQ-007 writedata_3  input  32  store data.
REQ-008 Rd_3  input  5  destination register.
REQ-009 memory_stall  output  1  freezes IF/ID/EX and the EX/MEM register while high.
REQ-010 DCACHE_ren  output  1  data cache read request.
REQ-011 DCACHE_wen  output  1  data cache write request.
REQ-012 DCACHE_addr  output  ADDR_W  word address = byte address [ADDR_W+1:2].
REQ-013 DCACHE_wdata  output  32  cache write data.
REQ-014 DCACHE_rdata  input  32  cache read data, valid in the acknowledge cycle.
REQ-015 DCACHE_stall  input  1  cache busy; acknowledge = first WAIT cycle with DCACHE_stall low.
REQ-016 WriteBack_4, Rd_4, writeback_data_4  output  1/5/32  MEM/WB register outputs.

Function
REQ-017 FSM states IDLE, WAIT; IDLE after reset.
REQ-018 IDLE, Mem_3 != 0: assert request (ren if bit1 set, else wen), memory_stall=1, go to WAIT.
REQ-019 WAIT: hold request, address and wdata stable; memory_stall = DCACHE_stall; on acknowledge go to IDLE.
REQ-020 Mem_3 = 2'b11 is treated as a read only; DCACHE_wen stays 0.
REQ-021 Minimum memory-op latency 2 cycles (IDLE + acknowledging WAIT); memory_stall never high for non-memory ops.
REQ-022 Request outputs are 0 and DCACHE_wdata/addr are don't-care-but-driven whenever no request is asserted.
REQ-023 MEM/WB register loads only in cycles with memory_stall low; it holds its value while memory_stall is high.
REQ-024 Load value: writeback_data_4 <= DCACHE_rdata captured in the acknowledge cycle; otherwise writeback_data_4 <= ALU_result_3.
REQ-025 WriteBack_4 <= WriteBack_3 and Rd_4 <= Rd_3 on every load of the MEM/WB register; stores carry WriteBack_3 unchanged.
REQ-026 Address low bits [1:0] are ignored; no misalignment detection.
REQ-027 Back-to-back memory ops: the next op starts in IDLE the cycle after acknowledge.

Reset
REQ-028 rst high forces, without waiting for clk: state IDLE, WriteBack_4=0, Rd_4=0, writeback_data_4=0, memory_stall=0, DCACHE_ren=0, DCACHE_wen=0.
REQ-029 Reset during WAIT abandons the pending access; no write-back of it occurs after reset release.

Configuration
REQ-030 Macro MEM_STORE_BUFFER_EN selects a one-entry posted store buffer.
REQ-031 Without it: stores stall exactly as loads (REQ-018/019).
REQ-032 With it: store in IDLE with buffer empty captures address/data, memory_stall=0 that cycle; buffer drains via DCACHE_wen in following cycles until acknowledge.
REQ-033 With it: any memory op arriving while the buffer is occupied stalls until the drain acknowledges, then proceeds per REQ-018; a load never bypasses the buffered store.
REQ-034 With it: reset empties the buffer; buffered store is lost.

Verification
REQ-035 WriteBack_3=1, Rd_3=5, Mem_3=0, ALU_result_3=0x00001234 -> next cycle WriteBack_4=1, Rd_4=5, writeback_data_4=0x00001234, memory_stall stays 0.
REQ-036 Load Mem_3=2'b10, ALU_result_3=0x00000100, DCACHE_stall high 3 WAIT cycles then low, rdata=0xDEADBEEF -> DCACHE_addr=0x40, memory_stall high 4 cycles, then writeback_data_4=0xDEADBEEF.
REQ-037 Store Mem_3=2'b01, address 0x8, writedata_3=0xA5A5A5A5, no cache stall, macro off -> wen with addr 0x2, wdata 0xA5A5A5A5, memory_stall high exactly 1 cycle.
REQ-038 rst pulse during WAIT of REQ-036 -> all outputs 0 immediately, no write-back of 0xDEADBEEF after release.
REQ-039 Mem_3=2'b11 -> DCACHE_ren=1, DCACHE_wen=0, loaded data written back.
REQ-040 Macro on: store to 0x8 then load from 0x8 on the next cycle -> store causes no stall, load stalls until drain acknowledges, then returns stored value from cache.

Source files
------------

// File: rtl/memory_access_if.sv
// Memory-stage bundle: EX/MEM pipeline inputs, data-cache request/response and MEM/WB outputs.
// slave = memory stage, master = surrounding pipeline + cache.
interface memory_access_if #(
  parameter int ADDR_W = 30
);
  logic              WriteBack_3;
  logic [1:0]        Mem_3;
  logic [31:0]       ALU_result_3;
  logic [31:0]       writedata_3;
  logic [4:0]        Rd_3;

  logic              memory_stall;

  logic              DCACHE_ren;
  logic              DCACHE_wen;
  logic [ADDR_W-1:0] DCACHE_addr;
  logic [31:0]       DCACHE_wdata;
  logic [31:0]       DCACHE_rdata;
  logic              DCACHE_stall;

  logic              WriteBack_4;
  logic [4:0]        Rd_4;
  logic [31:0]       writeback_data_4;

  modport slave (
    input  WriteBack_3, Mem_3, ALU_result_3, writedata_3, Rd_3,
    input  DCACHE_rdata, DCACHE_stall,
    output memory_stall, DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    output WriteBack_4, Rd_4, writeback_data_4
  );

  modport master (
    output WriteBack_3, Mem_3, ALU_result_3, writedata_3, Rd_3,
    output DCACHE_rdata, DCACHE_stall,
    input  memory_stall, DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
    input  WriteBack_4, Rd_4, writeback_data_4
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage + MEM/WB register: memory ops take >=2 cycles, stall follows DCACHE_stall until acknowledge.
// `MEM_STORE_BUFFER_EN adds a one-entry posted store buffer so isolated stores do not stall.
module memory_access #(
  parameter int ADDR_W = 30
) (
  input logic           clk,
  input logic           rst,
  memory_access_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        r_state;
  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              r_wb;
  logic [4:0]        r_rd;
  logic [31:0]       r_wb_data;

  logic              w_mem_op;
  logic              w_start;
  logic              w_ack;
  logic              w_stall;
  logic              w_ren;
  logic              w_wen;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_op_addr;

  assign w_mem_op  = |bus.Mem_3;
  assign w_op_addr = bus.ALU_result_3[ADDR_W+1:2];

`ifdef MEM_STORE_BUFFER_EN
  logic              r_sb_vld;
  logic [ADDR_W-1:0] r_sb_addr;
  logic [31:0]       r_sb_wdata;
  logic              w_sb_push;
  logic              w_sb_ack;

  // Any op behind a buffered store waits for the drain, so loads always see the stored data.
  always_comb begin
    w_ren     = 1'b0;
    w_wen     = 1'b0;
    w_addr    = w_op_addr;
    w_wdata   = bus.writedata_3;
    w_stall   = 1'b0;
    w_start   = 1'b0;
    w_ack     = 1'b0;
    w_sb_push = 1'b0;
    w_sb_ack  = 1'b0;
    if (!rst) begin
      if (r_state == WAIT) begin
        w_ren   = r_ren;
        w_wen   = r_wen;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_stall = bus.DCACHE_stall;
        w_ack   = !bus.DCACHE_stall;
      end else if (r_sb_vld) begin
        w_wen    = 1'b1;
        w_addr   = r_sb_addr;
        w_wdata  = r_sb_wdata;
        w_sb_ack = !bus.DCACHE_stall;
        w_stall  = w_mem_op;
      end else if (bus.Mem_3[1]) begin
        w_ren   = 1'b1;
        w_stall = 1'b1;
        w_start = 1'b1;
      end else if (w_mem_op) begin
        w_sb_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_vld   <= 1'b0;
      r_sb_addr  <= '0;
      r_sb_wdata <= '0;
    end else if (w_sb_push) begin
      r_sb_vld   <= 1'b1;
      r_sb_addr  <= w_op_addr;
      r_sb_wdata <= bus.writedata_3;
    end else if (w_sb_ack) begin
      r_sb_vld   <= 1'b0;
    end
  end
`else
  // Read wins when both Mem_3 bits are set.
  always_comb begin
    w_ren   = 1'b0;
    w_wen   = 1'b0;
    w_addr  = w_op_addr;
    w_wdata = bus.writedata_3;
    w_stall = 1'b0;
    w_start = 1'b0;
    w_ack   = 1'b0;
    if (!rst) begin
      if (r_state == WAIT) begin
        w_ren   = r_ren;
        w_wen   = r_wen;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_stall = bus.DCACHE_stall;
        w_ack   = !bus.DCACHE_stall;
      end else if (w_mem_op) begin
        w_ren   = bus.Mem_3[1];
        w_wen   = !bus.Mem_3[1];
        w_stall = 1'b1;
        w_start = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_state <= WAIT;
      r_ren   <= w_ren;
      r_wen   <= w_wen;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end else if (w_ack) begin
      r_state <= IDLE;
    end
  end

  // MEM/WB freezes with the rest of the pipe; read data is only valid in the acknowledge cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb      <= 1'b0;
      r_rd      <= '0;
      r_wb_data <= '0;
    end else if (!w_stall) begin
      r_wb      <= bus.WriteBack_3;
      r_rd      <= bus.Rd_3;
      r_wb_data <= (w_ack && r_ren) ? bus.DCACHE_rdata : bus.ALU_result_3;
    end
  end

  assign bus.memory_stall     = w_stall;
  assign bus.DCACHE_ren       = w_ren;
  assign bus.DCACHE_wen       = w_wen;
  assign bus.DCACHE_addr      = w_addr;
  assign bus.DCACHE_wdata     = w_wdata;
  assign bus.WriteBack_4      = r_wb;
  assign bus.Rd_4             = r_rd;
  assign bus.writeback_data_4 = r_wb_data;

endmodule
